// File: rtl/scoreboard_regfile.sv
// scoreboard_regfile
// Integer register file with a per-register pending-writer scoreboard.
// Decode reads NRD source operands and issues writers. Writeback retires
// results. x0 is hardwired to zero. Same-cycle writeback forwarding is
// optional. RAW/WAW hazards raise stall. A counter tracks how many
// registers are busy, and a sticky flag records writebacks to idle registers.
module scoreboard_regfile #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_rd,
   output logic                stall,
   input  logic                wb_valid,
   input  logic [AW-1:0]       wb_rd,
   input  logic [XLEN-1:0]     wb_data,
   output logic [AW:0]         pend_cnt,
   output logic                wb_err
);

   localparam logic BypassOn = (BYPASS != 0);

   logic [XLEN-1:0] r_regs [NREGS];
   logic [NREGS-1:0] r_busy;
   logic [AW:0]      r_pendCnt;
   logic             r_wbErr;

   logic             w_wbWr;
   logic             w_issHit;
   logic             w_issBusy;
   logic             w_acc;
   logic             w_setRise;
   logic             w_clrFall;
   logic [NREGS-1:0] w_busyNext;

   // A writeback matches address a only when forwarding is enabled and a is not x0.
   function automatic logic wbHit(input logic [AW-1:0] a);
      return BypassOn && wb_valid && (wb_rd == a) && (a != '0);
   endfunction

   // x0 reads zero. A forwarded writeback beats the stored value.
   function automatic logic [XLEN-1:0] readData(input logic [AW-1:0] a);
      logic [XLEN-1:0] v;
      if (a == '0) begin
         v = '0;
      end else if (wbHit(a)) begin
         v = wb_data;
      end else begin
         v = r_regs[a];
      end
      return v;
   endfunction

   // A register being retired this cycle is no longer treated as busy when forwarding is on.
   function automatic logic effBusy(input logic [AW-1:0] a);
      return r_busy[a] && !wbHit(a);
   endfunction

   assign w_wbWr    = wb_valid && (wb_rd != '0);
   assign w_issHit  = wbHit(iss_rd);
   assign w_issBusy = r_busy[iss_rd] && !w_issHit;
   assign stall     = iss_valid && ((|rd_busy) || w_issBusy);
   assign w_acc     = iss_valid && !stall && (iss_rd != '0);

   // The counter moves only on real busy-bit transitions.
   // A set and a clear on the same register cancel, so the counter does not move.
   assign w_setRise = w_acc && !r_busy[iss_rd];
   assign w_clrFall = w_wbWr && r_busy[wb_rd] && !(w_acc && (iss_rd == wb_rd));

   assign pend_cnt = r_pendCnt;
   assign wb_err   = r_wbErr;

   // Combinational read ports: data plus effective busy for each port.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         rd_data[i*XLEN +: XLEN] = readData(rd_addr[i*AW +: AW]);
         rd_busy[i]              = effBusy(rd_addr[i*AW +: AW]);
      end
   end

   // Next scoreboard: the retire clears first, then the accepted issue sets, so the new writer wins.
   always_comb begin
      w_busyNext = r_busy;
      if (w_wbWr) begin
         w_busyNext[wb_rd] = 1'b0;
      end
      if (w_acc) begin
         w_busyNext[iss_rd] = 1'b1;
      end
      w_busyNext[0] = 1'b0;
   end

   // State update. Reset wipes data, scoreboard, counter and error, and drops any writeback in that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            r_regs[r] <= '0;
         end
         r_busy    <= '0;
         r_pendCnt <= '0;
         r_wbErr   <= 1'b0;
      end else begin
         if (w_wbWr) begin
            r_regs[wb_rd] <= wb_data;
            if (!r_busy[wb_rd]) begin
               r_wbErr <= 1'b1;
            end
         end
         r_busy    <= w_busyNext;
         r_pendCnt <= r_pendCnt + {{AW{1'b0}}, w_setRise} - {{AW{1'b0}}, w_clrFall};
      end
   end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// tb_scoreboard_regfile
// Drives a forwarding instance and a non-forwarding instance with shared inputs.
// Both are compared every cycle against a behavioural model of the register file
// and its scoreboard. Directed vectors also carry hand-derived expectations
// for the forwarding instance.
module tb_scoreboard_regfile;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;

   logic                clk = 1'b0;
   logic                rst;
   logic [AW-1:0]       addr0, addr1;
   logic [NRD*AW-1:0]   rdAddr;
   logic [NRD*XLEN-1:0] rdData, rdDataNb;
   logic [NRD-1:0]      rdBusy, rdBusyNb;
   logic                issValid;
   logic [AW-1:0]       issRd;
   logic                stall, stallNb;
   logic                wbValid;
   logic [AW-1:0]       wbRd;
   logic [XLEN-1:0]     wbData;
   logic [AW:0]         pendCnt, pendCntNb;
   logic                wbErr, wbErrNb;

   int nChecks = 0;
   int nErrors = 0;

   // Model state: one shared data array, one scoreboard per instance (index 1 = forwarding).
   logic [XLEN-1:0] mRegs [NREGS];
   bit              mBusy [2][NREGS];
   bit              mErr  [2];

   typedef struct {
      string           name;
      bit              iv;
      logic [AW-1:0]   ir;
      bit              wv;
      logic [AW-1:0]   wr;
      logic [XLEN-1:0] wd;
      logic [AW-1:0]   a0;
      logic [AW-1:0]   a1;
      logic [XLEN-1:0] e0;
      logic [XLEN-1:0] e1;
      logic [XLEN-1:0] eNb;
      logic [1:0]      eBusy;
      bit              eStall;
      logic [AW:0]     eCnt;
      bit              eErr;
   } vec_t;

   vec_t vecs [17];

   assign rdAddr = {addr1, addr0};

   always #5 clk = ~clk;

   scoreboard_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rdData), .rd_busy(rdBusy),
      .iss_valid(issValid), .iss_rd(issRd), .stall(stall),
      .wb_valid(wbValid), .wb_rd(wbRd), .wb_data(wbData),
      .pend_cnt(pendCnt), .wb_err(wbErr)
   );

   scoreboard_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dutNb (
      .clk(clk), .rst(rst), .rd_addr(rdAddr), .rd_data(rdDataNb), .rd_busy(rdBusyNb),
      .iss_valid(issValid), .iss_rd(issRd), .stall(stallNb),
      .wb_valid(wbValid), .wb_rd(wbRd), .wb_data(wbData),
      .pend_cnt(pendCntNb), .wb_err(wbErrNb)
   );

   function automatic bit mHit(int b, logic [AW-1:0] a);
      return (b == 1) && wbValid && (wbRd == a) && (a != 0);
   endfunction

   function automatic logic [XLEN-1:0] mData(int b, logic [AW-1:0] a);
      if (a == 0) return '0;
      if (mHit(b, a)) return wbData;
      return mRegs[a];
   endfunction

   function automatic bit mEBusy(int b, logic [AW-1:0] a);
      return mBusy[b][a] && !mHit(b, a);
   endfunction

   function automatic bit mStall(int b);
      return issValid && (mEBusy(b, addr0) || mEBusy(b, addr1) || mEBusy(b, issRd));
   endfunction

   function automatic int mPop(int b);
      int n = 0;
      for (int r = 0; r < NREGS; r++) n += int'(mBusy[b][r]);
      return n;
   endfunction

   // Advance the model at every rising edge using the inputs held through that edge.
   always @(posedge clk) begin
      bit acc [2];
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            mRegs[r] = '0;
            mBusy[0][r] = 1'b0;
            mBusy[1][r] = 1'b0;
         end
         mErr[0] = 1'b0;
         mErr[1] = 1'b0;
      end else begin
         for (int b = 0; b < 2; b++) acc[b] = issValid && !mStall(b) && (issRd != 0);
         if (wbValid && wbRd != 0) begin
            mRegs[wbRd] = wbData;
            for (int b = 0; b < 2; b++) begin
               if (!mBusy[b][wbRd]) mErr[b] = 1'b1;
               mBusy[b][wbRd] = 1'b0;
            end
         end
         for (int b = 0; b < 2; b++) if (acc[b]) mBusy[b][issRd] = 1'b1;
      end
   end

   task automatic checkVal(string name, logic [63:0] act, logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Compare both instances against the model state in the current cycle.
   task automatic modelCheck(string tag);
      checkVal({tag, ":d0"},     rdData[31:0],    mData(1, addr0));
      checkVal({tag, ":d1"},     rdData[63:32],   mData(1, addr1));
      checkVal({tag, ":busy"},   rdBusy,          {mEBusy(1, addr1), mEBusy(1, addr0)});
      checkVal({tag, ":stall"},  stall,           mStall(1));
      checkVal({tag, ":cnt"},    pendCnt,         mPop(1));
      checkVal({tag, ":err"},    wbErr,           mErr[1]);
      checkVal({tag, ":nb_d0"},  rdDataNb[31:0],  mData(0, addr0));
      checkVal({tag, ":nb_d1"},  rdDataNb[63:32], mData(0, addr1));
      checkVal({tag, ":nb_bsy"}, rdBusyNb,        {mEBusy(0, addr1), mEBusy(0, addr0)});
      checkVal({tag, ":nb_stl"}, stallNb,         mStall(0));
      checkVal({tag, ":nb_cnt"}, pendCntNb,       mPop(0));
      checkVal({tag, ":nb_err"}, wbErrNb,         mErr[0]);
   endtask

   // Drive one cycle of inputs after the falling edge, then check the outputs before the next rising edge.
   task automatic applyStimulus(string tag, bit r, bit iv, logic [AW-1:0] ir, bit wv,
                                logic [AW-1:0] wr, logic [XLEN-1:0] wd,
                                logic [AW-1:0] a0, logic [AW-1:0] a1);
      @(negedge clk);
      rst = r; issValid = iv; issRd = ir; wbValid = wv; wbRd = wr; wbData = wd;
      addr0 = a0; addr1 = a1;
      #1;
      modelCheck(tag);
   endtask

   // Check the forwarding instance against hand-derived values.
   task automatic checkOutput(string tag, logic [XLEN-1:0] e0, logic [XLEN-1:0] e1,
                              logic [XLEN-1:0] eNb, logic [1:0] eBusy, bit eStall,
                              logic [AW:0] eCnt, bit eErr);
      checkVal({tag, ":t_d0"},    rdData[31:0],   e0);
      checkVal({tag, ":t_d1"},    rdData[63:32],  e1);
      checkVal({tag, ":t_nb_d0"}, rdDataNb[31:0], eNb);
      checkVal({tag, ":t_busy"},  rdBusy,         eBusy);
      checkVal({tag, ":t_stall"}, stall,          eStall);
      checkVal({tag, ":t_cnt"},   pendCnt,        eCnt);
      checkVal({tag, ":t_err"},   wbErr,          eErr);
   endtask

   initial begin
      rst = 1'b1; issValid = 1'b0; issRd = '0; wbValid = 1'b0; wbRd = '0; wbData = '0;
      addr0 = '0; addr1 = '0;

      //                name           iv ir  wv wr  wd            a0  a1  e0            e1            eNb           busy   st cnt err
      vecs[0]  = '{"iss_x5",       1, 5,  0, 0,  32'h0,        5,  0,  32'h0,        32'h0,        32'h0,        2'b00, 0, 0, 0};
      vecs[1]  = '{"wb_x5_byp",    0, 0,  1, 5,  32'hDEADBEEF, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        2'b00, 0, 1, 0};
      vecs[2]  = '{"rd_x5_next",   0, 0,  0, 0,  32'h0,        5,  0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 2'b00, 0, 0, 0};
      vecs[3]  = '{"wb_x0",        0, 0,  1, 0,  32'h1234,     0,  0,  32'h0,        32'h0,        32'h0,        2'b00, 0, 0, 0};
      vecs[4]  = '{"x0_after",     0, 0,  0, 0,  32'h0,        0,  5,  32'h0,        32'hDEADBEEF, 32'h0,        2'b00, 0, 0, 0};
      vecs[5]  = '{"iss_x7",       1, 7,  0, 0,  32'h0,        0,  0,  32'h0,        32'h0,        32'h0,        2'b00, 0, 0, 0};
      vecs[6]  = '{"iss_x9_raw",   1, 9,  0, 0,  32'h0,        7,  3,  32'h0,        32'h0,        32'h0,        2'b01, 1, 1, 0};
      vecs[7]  = '{"iss_x9_wb7",   1, 9,  1, 7,  32'h77,       7,  3,  32'h77,       32'h0,        32'h0,        2'b00, 0, 1, 0};
      vecs[8]  = '{"x9_busy",      0, 0,  0, 0,  32'h0,        9,  7,  32'h0,        32'h77,       32'h0,        2'b01, 0, 1, 0};
      vecs[9]  = '{"iss_x4",       1, 4,  0, 0,  32'h0,        4,  0,  32'h0,        32'h0,        32'h0,        2'b00, 0, 1, 0};
      vecs[10] = '{"reiss_x4_waw", 1, 4,  0, 0,  32'h0,        0,  0,  32'h0,        32'h0,        32'h0,        2'b00, 1, 2, 0};
      vecs[11] = '{"wb4_iss4",     1, 4,  1, 4,  32'h44,       4,  0,  32'h44,       32'h0,        32'h0,        2'b00, 0, 2, 0};
      vecs[12] = '{"x4_still_bsy", 0, 0,  0, 0,  32'h0,        4,  9,  32'h44,       32'h0,        32'h44,       2'b11, 0, 2, 0};
      vecs[13] = '{"wb_x12_idle",  0, 0,  1, 12, 32'hC0FFEE,   12, 0,  32'hC0FFEE,   32'h0,        32'h0,        2'b00, 0, 2, 0};
      vecs[14] = '{"err_set",      0, 0,  0, 0,  32'h0,        12, 4,  32'hC0FFEE,   32'h44,       32'hC0FFEE,   2'b10, 0, 2, 1};
      vecs[15] = '{"err_sticky",   0, 0,  1, 9,  32'h99,       9,  12, 32'h99,       32'hC0FFEE,   32'h0,        2'b00, 0, 2, 1};
      vecs[16] = '{"wb_x4_retire", 0, 0,  1, 4,  32'h4444,     4,  0,  32'h4444,     32'h0,        32'h44,       2'b00, 0, 1, 1};

      repeat (2) @(posedge clk);
      $display("[TB] reset sweep");
      for (int a = 0; a < NREGS; a++) begin
         applyStimulus("rst_sweep", 1'b0, 1'b0, '0, 1'b0, '0, '0, AW'(a), AW'(NREGS-1-a));
         checkOutput("rst_sweep", '0, '0, '0, 2'b00, 1'b0, '0, 1'b0);
      end

      $display("[TB] directed vectors");
      for (int v = 0; v < 17; v++) begin
         applyStimulus(vecs[v].name, 1'b0, vecs[v].iv, vecs[v].ir, vecs[v].wv, vecs[v].wr,
                       vecs[v].wd, vecs[v].a0, vecs[v].a1);
         checkOutput(vecs[v].name, vecs[v].e0, vecs[v].e1, vecs[v].eNb, vecs[v].eBusy,
                     vecs[v].eStall, vecs[v].eCnt, vecs[v].eErr);
      end

      $display("[TB] fill x1..x31");
      for (int r = 1; r < NREGS; r++) begin
         applyStimulus("fill", 1'b0, 1'b1, AW'(r), 1'b0, '0, '0, '0, '0);
      end
      applyStimulus("fill_done", 1'b0, 1'b0, '0, 1'b0, '0, '0, 5, 31);
      checkVal("fill_cnt31", pendCnt, 31);
      checkVal("fill_busy", rdBusy, 2'b11);
      applyStimulus("mid_reset", 1'b1, 1'b1, 3, 1'b1, 6, 32'hFFFF, 0, 0);
      for (int a = 0; a < NREGS; a++) begin
         applyStimulus("post_rst", 1'b0, 1'b0, '0, 1'b0, '0, '0, AW'(a), AW'(NREGS-1-a));
         checkOutput("post_rst", '0, '0, '0, 2'b00, 1'b0, '0, 1'b0);
      end

      $display("[TB] random traffic");
      for (int n = 0; n < 400; n++) begin
         applyStimulus("rand", ($urandom_range(0, 49) == 0),
                       1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom(),
                       AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      end

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
